// File: rtl/d3s_phase_extract.sv
// d3s_phase_extract: recovers the 14-bit phase and the uncompensated magnitude
// of a signed I/Q sample pair using an iterative vectoring-mode CORDIC
// (one micro-rotation per clock).
//
// Phase format matches the DAC LUT input: full circle = 2^14, bit 13 selects
// the half circle, bits 12:0 give the phase within that half.
//
// Ports:
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   i_i      : in-phase sample, two's complement (14 bit)
//   q_i      : quadrature sample, two's complement (14 bit)
//   valid_i  : input sample valid
//   ready_o  : block can accept a sample (high only in IDLE)
//   phase_o  : recovered phase, unsigned modulo 2^14
//   mag_o    : uncompensated magnitude (CORDIC gain ~1.647), unsigned
//   zero_o   : result came from I = Q = 0
//   valid_o  : one-cycle result strobe
module d3s_phase_extract #(
   parameter int unsigned g_iterations = 12,
   parameter int unsigned g_frac_bits  = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [13:0] i_i,
   input  logic [13:0] q_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [13:0] phase_o,
   output logic [15:0] mag_o,
   output logic        zero_o,
   output logic        valid_o
);

   localparam int unsigned c_in_w  = 14;
   localparam int unsigned c_ext_w = 16;
   localparam int unsigned c_w     = c_ext_w + g_frac_bits;
   localparam int unsigned c_ph_w  = 14;
   localparam int unsigned c_mag_w = 16;
   localparam int unsigned c_k_w   = 4;

   localparam logic [c_ph_w-1:0] c_half_circle = c_ph_w'(8192);
   localparam logic [c_k_w-1:0]  c_k_last      = c_k_w'(g_iterations - 1);

   typedef enum logic [1:0] {
      IDLE,
      ROT,
      DONE
   } state_t;

   // atan(2^-k) in phase LSBs: round(2^14 * atan(2^-k) / 2pi)
   function automatic logic [c_ph_w-1:0] atan_lut(input logic [c_k_w-1:0] k);
      logic [c_ph_w-1:0] a;
      a = '0;
      case (k)
         4'd0:    a = c_ph_w'(2048);
         4'd1:    a = c_ph_w'(1209);
         4'd2:    a = c_ph_w'(639);
         4'd3:    a = c_ph_w'(324);
         4'd4:    a = c_ph_w'(163);
         4'd5:    a = c_ph_w'(81);
         4'd6:    a = c_ph_w'(41);
         4'd7:    a = c_ph_w'(20);
         4'd8:    a = c_ph_w'(10);
         4'd9:    a = c_ph_w'(5);
         4'd10:   a = c_ph_w'(3);
         4'd11:   a = c_ph_w'(1);
         default: a = '0;
      endcase
      return a;
   endfunction

   state_t                   state_q, state_d;
   logic signed [c_w-1:0]    x_q, x_d;
   logic signed [c_w-1:0]    y_q, y_d;
   logic [c_ph_w-1:0]        z_q, z_d;
   logic [c_k_w-1:0]         k_q, k_d;
   logic                     zero_flag_q, zero_flag_d;
   logic                     ready_q, ready_d;
   logic                     valid_q, valid_d;
   logic [c_ph_w-1:0]        phase_q, phase_d;
   logic [c_mag_w-1:0]       mag_q, mag_d;
   logic                     zero_q, zero_d;

   logic signed [c_w-1:0]    i_ld;
   logic signed [c_w-1:0]    q_ld;
   logic signed [c_w-1:0]    x_sh;
   logic signed [c_w-1:0]    y_sh;
   logic [c_ph_w-1:0]        atan_k;

   // Sign-extend to 16 bits, then append the guard fraction bits.
   assign i_ld = c_w'(signed'(i_i)) <<< g_frac_bits;
   assign q_ld = c_w'(signed'(q_i)) <<< g_frac_bits;

   assign x_sh   = x_q >>> k_q;
   assign y_sh   = y_q >>> k_q;
   assign atan_k = atan_lut(k_q);

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         k_q         <= '0;
         zero_flag_q <= 1'b0;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
         phase_q     <= '0;
         mag_q       <= '0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         k_q         <= k_d;
         zero_flag_q <= zero_flag_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
         phase_q     <= phase_d;
         mag_q       <= mag_d;
         zero_q      <= zero_d;
      end
   end

   // Next-state, datapath and output logic.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      k_d         = k_q;
      zero_flag_d = zero_flag_q;
      valid_d     = 1'b0;
      phase_d     = phase_q;
      mag_d       = mag_q;
      zero_d      = zero_q;

      case (state_q)
         IDLE: begin
            if (valid_i && ready_q) begin
               zero_flag_d = (i_i == '0) && (q_i == '0);
               // Left half-plane: rotate by 180 degrees so the CORDIC
               // only has to cover +-90 degrees.
               if (i_i[c_in_w-1]) begin
                  x_d = -i_ld;
                  y_d = -q_ld;
                  z_d = c_half_circle;
               end else begin
                  x_d = i_ld;
                  y_d = q_ld;
                  z_d = '0;
               end
               k_d     = '0;
               state_d = ROT;
            end
         end

         ROT: begin
            // y = 0 counts as non-negative.
            if (!y_q[c_w-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_k;
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_k;
            end
            k_d = k_q + c_k_w'(1);
            if (k_q == c_k_last) begin
               state_d = DONE;
            end
         end

         DONE: begin
            valid_d = 1'b1;
            zero_d  = zero_flag_q;
            if (zero_flag_q) begin
               phase_d = '0;
               mag_d   = '0;
            end else begin
               phase_d = z_q;
               // The shifted datapath is exactly 16 bits wide, so only a
               // negative x (never expected) needs clamping.
               mag_d = x_q[c_w-1] ? '0 : c_mag_w'(x_q >>> g_frac_bits);
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready_d = (state_d == IDLE);

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign phase_o = phase_q;
   assign mag_o   = mag_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_d3s_phase_extract.sv
// Directed self-checking bench for d3s_phase_extract: reset state, quadrants,
// diagonals, latency, handshake under continuous valid_i, zero vector,
// mid-operation reset, and a 4096-point angle sweep against atan2.
module tb_d3s_phase_extract;

   localparam real c_pi = 3.14159265358979323846;

   logic        clk;
   logic        rst_n;
   logic [13:0] i_s;
   logic [13:0] q_s;
   logic        valid_in;
   logic        ready;
   logic [13:0] phase;
   logic [15:0] mag;
   logic        zero;
   logic        valid_out;

   int n_total = 0;
   int n_bad   = 0;

   d3s_phase_extract dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .i_i     (i_s),
      .q_i     (q_s),
      .valid_i (valid_in),
      .ready_o (ready),
      .phase_o (phase),
      .mag_o   (mag),
      .zero_o  (zero),
      .valid_o (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare with optional tolerance; wrap selects modulo-2^14 distance.
   task automatic check(input string tag, input int got, input int exp,
                        input int tol = 0, input bit wrap = 1'b0);
      int d;
      n_total++;
      d = got - exp;
      if (wrap) begin
         d = d % 16384;
         if (d >= 8192) d -= 16384;
         else if (d < -8192) d += 16384;
      end
      if (d < 0) d = -d;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Present one sample, wait for its result; lat counts cycles after accept.
   task automatic send(input int ii, input int qq,
                       output int ph, output int mg, output int zf, output int lat);
      @(negedge clk);
      check("ready_before_send", int'(ready), 1);
      i_s      = 14'(ii);
      q_s      = 14'(qq);
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      lat = 0;
      while (!valid_out && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      ph = int'(phase);
      mg = int'(mag);
      zf = int'(zero);
   endtask

   typedef struct {
      int ii;
      int qq;
      int ph;
   } vec_t;

   vec_t hs_tab[5];
   int   hs_q[$];

   initial begin
      int ph, mg, zf, lat;
      int acc_cnt, last_acc, vcnt, idx;
      real ang, refp;
      int ii, qq, exp_ph;

      rst_n    = 1'b0;
      valid_in = 1'b0;
      i_s      = '0;
      q_s      = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", int'(ready), 1);
      check("rst_valid", int'(valid_out), 0);
      check("rst_phase", int'(phase), 0);
      check("rst_mag", int'(mag), 0);
      check("rst_zero", int'(zero), 0);
      rst_n = 1'b1;

      // Quadrants
      send(4000, 0, ph, mg, zf, lat);
      check("q0_phase", ph, 0, 2, 1'b1);
      check("q0_mag", mg, 6588, 8);
      check("q0_lat", lat, 13);
      @(negedge clk);
      check("q0_valid_one_cycle", int'(valid_out), 0);
      send(0, 4000, ph, mg, zf, lat);
      check("q1_phase", ph, 4096, 2, 1'b1);
      check("q1_mag", mg, 6588, 8);
      check("q1_lat", lat, 13);
      send(-4000, 0, ph, mg, zf, lat);
      check("q2_phase", ph, 8192, 2, 1'b1);
      check("q2_mag", mg, 6588, 8);
      check("q2_lat", lat, 13);
      send(0, -4000, ph, mg, zf, lat);
      check("q3_phase", ph, 12288, 2, 1'b1);
      check("q3_mag", mg, 6588, 8);
      check("q3_lat", lat, 13);
      check("q3_zero", zf, 0);

      // Diagonals
      send(2000, 2000, ph, mg, zf, lat);
      check("d45_phase", ph, 2048, 2, 1'b1);
      send(-2000, 2000, ph, mg, zf, lat);
      check("d135_phase", ph, 6144, 2, 1'b1);
      send(-8192, -8192, ph, mg, zf, lat);
      check("d225_phase", ph, 10240, 2, 1'b1);
      check("d225_mag", mg, 19083, 20);
      repeat (5) @(negedge clk);
      check("hold_phase", int'(phase), 10240, 2, 1'b1);
      check("hold_mag", int'(mag), 19083, 20);

      // Handshake: valid_i held high, new sample every cycle
      hs_tab[0] = '{4000, 0, 0};
      hs_tab[1] = '{0, 4000, 4096};
      hs_tab[2] = '{-4000, 0, 8192};
      hs_tab[3] = '{0, -4000, 12288};
      hs_tab[4] = '{2000, 2000, 2048};
      acc_cnt  = 0;
      last_acc = -1;
      vcnt     = 0;
      for (int n = 0; n < 75; n++) begin
         @(negedge clk);
         if (valid_out) begin
            vcnt++;
            if (hs_q.size() > 0) begin
               idx = hs_q.pop_front();
               check("hs_phase", int'(phase), hs_tab[idx].ph, 2, 1'b1);
            end else begin
               check("hs_unexpected_valid", 1, 0);
            end
         end
         if (n < 45) begin
            i_s      = 14'(hs_tab[n % 5].ii);
            q_s      = 14'(hs_tab[n % 5].qq);
            valid_in = 1'b1;
            if (ready) begin
               if (last_acc >= 0) check("hs_spacing", n - last_acc, 14);
               last_acc = n;
               acc_cnt++;
               hs_q.push_back(n % 5);
            end
         end else begin
            valid_in = 1'b0;
         end
      end
      check("hs_accepts", acc_cnt, 4);
      check("hs_results", vcnt, 4);
      check("hs_pending", hs_q.size(), 0);

      // Zero vector, then a non-zero follow-up
      send(0, 0, ph, mg, zf, lat);
      check("z_phase", ph, 0);
      check("z_mag", mg, 0);
      check("z_flag", zf, 1);
      check("z_lat", lat, 13);
      send(100, 0, ph, mg, zf, lat);
      check("z_next_flag", zf, 0);
      check("z_next_phase", ph, 0, 2, 1'b1);

      // Mid-operation reset
      send(3000, 1000, ph, mg, zf, lat);
      @(negedge clk);
      i_s      = 14'(0);
      q_s      = 14'(4000);
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mr_phase", int'(phase), 0);
      check("mr_mag", int'(mag), 0);
      check("mr_valid", int'(valid_out), 0);
      check("mr_ready", int'(ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (valid_out) vcnt++;
      end
      check("mr_no_valid", vcnt, 0);
      check("mr_ready_after", int'(ready), 1);
      send(0, 4000, ph, mg, zf, lat);
      check("mr_resume_phase", ph, 4096, 2, 1'b1);
      check("mr_resume_lat", lat, 13);

      // Angle sweep, radius 6000; reference rounded to the nearest LSB
      for (int a = 0; a < 4096; a++) begin
         ang = 2.0 * c_pi * real'(a) / 4096.0;
         ii  = int'(6000.0 * $cos(ang));
         qq  = int'(6000.0 * $sin(ang));
         refp = $atan2(real'(qq), real'(ii)) * 16384.0 / (2.0 * c_pi);
         if (refp < 0.0) refp = refp + 16384.0;
         exp_ph = int'(refp) % 16384;
         send(ii, qq, ph, mg, zf, lat);
         check("sweep_phase", ph, exp_ph, 4, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
